// File: rtl/load_use_hazard_pkg.sv
// Shared definitions for the load-use hazard unit: register-id width, shadow
// entry layout, the bubble encoding and the pipeline stage indices.
package load_use_hazard_pkg;

   localparam int REG_W    = 4;
   localparam int NUM_REGS = 1 << REG_W;

   localparam int SLOT_EX  = 0;
   localparam int SLOT_MEM = 1;
   localparam int SLOT_WB  = 2;

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] dst;
      logic             ld;
   } shadow_entry_t;

   localparam shadow_entry_t NOP_ENTRY = '{v: 1'b0, dst: '0, ld: 1'b0};

   function automatic shadow_entry_t make_entry(input logic             v,
                                                input logic [REG_W-1:0] dst,
                                                input logic             ld);
      shadow_entry_t e;
      e.v   = v;
      e.dst = dst;
      e.ld  = ld;
      return e;
   endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the EX/MEM/WB destination fields. Advances with the pipeline
// and freezes while hold is high; insert_bubble issues an empty entry instead.
module hazard_shadow_pipe
   import load_use_hazard_pkg::*;
#(
   parameter int DEPTH = SLOT_WB + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      hold,
   input  logic                      insert_bubble,
   input  shadow_entry_t             in_entry,
   output shadow_entry_t [DEPTH-1:0] slots
);

   shadow_entry_t [DEPTH-1:0] slots_q;
   shadow_entry_t [DEPTH-1:0] slots_d;

   always_comb begin
      slots_d = slots_q;
      if (!hold) begin
         slots_d[SLOT_EX] = insert_bubble ? NOP_ENTRY : in_entry;
         for (int k = 1; k < DEPTH; k++) begin
            slots_d[k] = slots_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slots_q <= '0;
      end else begin
         slots_q <= slots_d;
      end
   end

   assign slots = slots_q;

endmodule

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detection, in-order writeback checking and stall accounting
// on top of a shadow pipeline of in-flight destination registers.
module load_use_hazard_unit
   import load_use_hazard_pkg::*;
#(
   parameter int DEPTH           = SLOT_WB + 1,
   parameter int LOAD_USE_STALLS = SLOT_MEM - SLOT_EX,
   parameter bit ZERO_REG        = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_W-1:0]    id_op1,
   input  logic [REG_W-1:0]    id_op2,
   input  logic                id_use1,
   input  logic                id_use2,
   input  logic                id_wr,
   input  logic [REG_W-1:0]    id_dst,
   input  logic                id_is_load,
   input  logic                mem_stall,
   input  logic                flush,
   input  logic                wb_valid,
   input  logic [REG_W-1:0]    wb_dst,
   output logic                stall_id,
   output logic                bubble_ex,
   output logic [NUM_REGS-1:0] pend_mask,
   output logic                wb_mismatch,
   output logic [15:0]         stall_cnt
);

   // id_valid and wb_valid qualify their payloads in the cycle they are high;
   // there is no back-pressure path other than stall_id toward ID.
   shadow_entry_t [DEPTH-1:0] slots;
   shadow_entry_t             wb_slot;
   logic                      hazard;
   logic                      wb_mismatch_q, wb_mismatch_d;
   logic [15:0]               stall_cnt_q, stall_cnt_d;

   function automatic logic src_hit(input logic             use_s,
                                    input logic [REG_W-1:0] src,
                                    input shadow_entry_t    e);
      return use_s && e.v && e.ld && (e.dst == src) && !(ZERO_REG && (src == '0));
   endfunction

   hazard_shadow_pipe #(.DEPTH(DEPTH)) u_shadow (
      .clk          (clk),
      .rst          (rst),
      .hold         (mem_stall),
      .insert_bubble(hazard | flush),
      .in_entry     (make_entry(id_valid & id_wr, id_dst, id_is_load)),
      .slots        (slots)
   );

   assign wb_slot = slots[DEPTH-1];

   // Only loads in the youngest slots are still unforwardable.
   always_comb begin
      hazard = 1'b0;
      for (int k = 0; k < LOAD_USE_STALLS; k++) begin
         if (src_hit(id_use1, id_op1, slots[k]) || src_hit(id_use2, id_op2, slots[k])) begin
            hazard = 1'b1;
         end
      end
      if (!id_valid || flush) begin
         hazard = 1'b0;
      end
   end

   assign stall_id  = mem_stall | hazard;
   assign bubble_ex = !mem_stall & (hazard | flush);

   always_comb begin
      pend_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (slots[k].v) begin
            pend_mask[slots[k].dst] = 1'b1;
         end
      end
      if (ZERO_REG) begin
         pend_mask[0] = 1'b0;
      end
   end

   always_comb begin
      wb_mismatch_d = wb_mismatch_q;
      stall_cnt_d   = stall_cnt_q;
      if (!mem_stall) begin
         if (wb_valid) begin
            if (!wb_slot.v || (wb_dst != wb_slot.dst)) begin
               wb_mismatch_d = 1'b1;
            end
         end else if (wb_slot.v) begin
            wb_mismatch_d = 1'b1;
         end
         if (hazard && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_mismatch_q <= 1'b0;
         stall_cnt_q   <= 16'd0;
      end else begin
         wb_mismatch_q <= wb_mismatch_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign wb_mismatch = wb_mismatch_q;
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Bench for load_use_hazard_unit: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an in-flight queue model.
module tb_load_use_hazard_unit;
   import load_use_hazard_pkg::*;

   localparam int DEPTH = 3;
   localparam int LUS   = 1;
   localparam bit ZR    = 1'b1;
   localparam int EW    = REG_W + 2;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                id_valid = 1'b0;
   logic [REG_W-1:0]    id_op1 = '0;
   logic [REG_W-1:0]    id_op2 = '0;
   logic                id_use1 = 1'b0;
   logic                id_use2 = 1'b0;
   logic                id_wr = 1'b0;
   logic [REG_W-1:0]    id_dst = '0;
   logic                id_is_load = 1'b0;
   logic                mem_stall = 1'b0;
   logic                flush = 1'b0;
   logic                wb_valid = 1'b0;
   logic [REG_W-1:0]    wb_dst = '0;
   logic                stall_id;
   logic                bubble_ex;
   logic [NUM_REGS-1:0] pend_mask;
   logic                wb_mismatch;
   logic [15:0]         stall_cnt;

   always #5 clk = ~clk;

   load_use_hazard_unit #(
      .DEPTH          (DEPTH),
      .LOAD_USE_STALLS(LUS),
      .ZERO_REG       (ZR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_op1     (id_op1),
      .id_op2     (id_op2),
      .id_use1    (id_use1),
      .id_use2    (id_use2),
      .id_wr      (id_wr),
      .id_dst     (id_dst),
      .id_is_load (id_is_load),
      .mem_stall  (mem_stall),
      .flush      (flush),
      .wb_valid   (wb_valid),
      .wb_dst     (wb_dst),
      .stall_id   (stall_id),
      .bubble_ex  (bubble_ex),
      .pend_mask  (pend_mask),
      .wb_mismatch(wb_mismatch),
      .stall_cnt  (stall_cnt)
   );

   int check_cnt = 0;
   int pass_cnt  = 0;
   bit check_en  = 1'b0;

   // In-flight instruction records, youngest first: {writes, is_load, dst}.
   logic [EW-1:0] exp_q[$];
   int            exp_stall_cnt = 0;
   bit            exp_mismatch  = 1'b0;
   bit            m_hz;
   bit            c_hz;
   logic [EW-1:0] m_old;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_hazard();
      bit hit = 1'b0;
      if (!id_valid || flush) return 1'b0;
      for (int k = 0; k < LUS; k++) begin
         if (exp_q[k][EW-1] && exp_q[k][REG_W]) begin
            if (id_use1 && id_op1 == exp_q[k][REG_W-1:0] && !(ZR && id_op1 == '0)) hit = 1'b1;
            if (id_use2 && id_op2 == exp_q[k][REG_W-1:0] && !(ZR && id_op2 == '0)) hit = 1'b1;
         end
      end
      return hit;
   endfunction

   function automatic logic [NUM_REGS-1:0] m_pend();
      int                  copies[NUM_REGS];
      logic [NUM_REGS-1:0] m = '0;
      foreach (copies[r]) copies[r] = 0;
      foreach (exp_q[i]) begin
         if (exp_q[i][EW-1]) copies[exp_q[i][REG_W-1:0]]++;
      end
      for (int r = (ZR ? 1 : 0); r < NUM_REGS; r++) begin
         if (copies[r] > 0) m[r] = 1'b1;
      end
      return m;
   endfunction

   // Reference model: updates on the same edges the pipeline advances on.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < DEPTH; i++) exp_q.push_back('0);
         exp_stall_cnt = 0;
         exp_mismatch  = 1'b0;
      end else if (!mem_stall) begin
         m_hz  = m_hazard();
         m_old = exp_q[DEPTH-1];
         if (wb_valid) begin
            if (!m_old[EW-1] || wb_dst != m_old[REG_W-1:0]) exp_mismatch = 1'b1;
         end else if (m_old[EW-1]) begin
            exp_mismatch = 1'b1;
         end
         if (m_hz && exp_stall_cnt < 65535) exp_stall_cnt++;
         exp_q.push_front({id_valid && id_wr && !m_hz && !flush, id_is_load, id_dst});
         void'(exp_q.pop_back());
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         c_hz = m_hazard();
         chk("stall_id",    32'(stall_id),    32'(mem_stall | c_hz));
         chk("bubble_ex",   32'(bubble_ex),   32'(!mem_stall & (c_hz | flush)));
         chk("pend_mask",   32'(pend_mask),   32'(m_pend()));
         chk("wb_mismatch", 32'(wb_mismatch), 32'(exp_mismatch));
         chk("stall_cnt",   32'(stall_cnt),   32'(exp_stall_cnt));
      end
   end

   task automatic wb_auto();
      wb_valid = exp_q[DEPTH-1][EW-1];
      wb_dst   = exp_q[DEPTH-1][REG_W-1:0];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      wb_auto();
   endtask

   task automatic set_id(input bit v, input logic [REG_W-1:0] op1, input logic [REG_W-1:0] op2,
                         input bit u1, input bit u2, input bit wr,
                         input logic [REG_W-1:0] dst, input bit ld);
      id_valid   = v;
      id_op1     = op1;
      id_op2     = op2;
      id_use1    = u1;
      id_use2    = u2;
      id_wr      = wr;
      id_dst     = dst;
      id_is_load = ld;
   endtask

   task automatic idle();
      set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      flush     = 1'b0;
      mem_stall = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wb_auto();
   endtask

   task automatic drain();
      idle();
      repeat (DEPTH) step();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) exp_q.push_back('0);
      #1;
      do_reset();
      check_en = 1'b1;
      #2;
      chk("rst_stall_id",    32'(stall_id),    32'd0);
      chk("rst_bubble_ex",   32'(bubble_ex),   32'd0);
      chk("rst_pend_mask",   32'(pend_mask),   32'd0);
      chk("rst_wb_mismatch", 32'(wb_mismatch), 32'd0);
      chk("rst_stall_cnt",   32'(stall_cnt),   32'd0);

      // Load r3 then add r5 = r3 + r4: one stall, then the add issues.
      set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1);
      step();
      set_id(1'b1, 4'd3, 4'd4, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0);
      #2;
      chk("lu_stall",  32'(stall_id),  32'd1);
      chk("lu_bubble", 32'(bubble_ex), 32'd1);
      chk("lu_pend",   32'(pend_mask), 32'h0008);
      step();
      #2;
      chk("lu_release_stall",  32'(stall_id),  32'd0);
      chk("lu_release_bubble", 32'(bubble_ex), 32'd0);
      step();
      idle();
      #2;
      chk("lu_cnt",  32'(stall_cnt), 32'd1);
      chk("lu_pend2", 32'(pend_mask), 32'h0028);
      drain();

      // ALU r3 then back-to-back reader: no stall, r3 pending for 3 cycles.
      set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
      step();
      set_id(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 4'd6, 1'b0);
      #2;
      chk("alu_stall", 32'(stall_id), 32'd0);
      chk("alu_pend0", 32'(pend_mask), 32'h0008);
      step();
      idle();
      #2;
      chk("alu_pend1", 32'(pend_mask), 32'h0008);
      step();
      #2;
      chk("alu_pend2", 32'(pend_mask), 32'h0008);
      step();
      #2;
      chk("alu_pend3", 32'(pend_mask), 32'h0000);

      // Load r0 with an r0 consumer: the zero register never stalls.
      set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
      step();
      set_id(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0);
      #2;
      chk("r0_stall", 32'(stall_id), 32'd0);
      chk("r0_pend",  32'(pend_mask), 32'h0000);
      step();
      drain();

      // Load r7, consumer waits behind a 4-cycle memory stall.
      do_reset();
      set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b1);
      step();
      set_id(1'b1, 4'd7, 4'd1, 1'b1, 1'b0, 1'b1, 4'd8, 1'b0);
      mem_stall = 1'b1;
      repeat (4) begin
         #2;
         chk("ms_stall",  32'(stall_id),  32'd1);
         chk("ms_bubble", 32'(bubble_ex), 32'd0);
         chk("ms_cnt",    32'(stall_cnt), 32'd0);
         chk("ms_pend",   32'(pend_mask), 32'h0080);
         step();
      end
      mem_stall = 1'b0;
      #2;
      chk("ms_hz_stall",  32'(stall_id),  32'd1);
      chk("ms_hz_bubble", 32'(bubble_ex), 32'd1);
      step();
      #2;
      chk("ms_go_stall", 32'(stall_id),  32'd0);
      chk("ms_cnt_after", 32'(stall_cnt), 32'd1);
      step();
      drain();

      // Load r2 with consumer of r2 squashed by flush in the same cycle.
      set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1);
      step();
      set_id(1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
      flush = 1'b1;
      #2;
      chk("fl_stall",  32'(stall_id),  32'd0);
      chk("fl_bubble", 32'(bubble_ex), 32'd1);
      step();
      idle();
      #2;
      chk("fl_pend", 32'(pend_mask), 32'h0004);
      drain();
      #2;
      chk("fl_mismatch", 32'(wb_mismatch), 32'd0);

      // Randomized traffic against the model.
      do_reset();
      repeat (1500) begin
         set_id($urandom_range(0, 99) < 85,
                4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 99) < 70,
                4'($urandom_range(0, 7)),
                $urandom_range(0, 99) < 45);
         mem_stall = $urandom_range(0, 99) < 12;
         flush     = $urandom_range(0, 99) < 8;
         step();
      end
      drain();
      #2;
      chk("rand_mismatch", 32'(wb_mismatch), 32'd0);

      // add r9 reaches WB but r8 is written back: sticky mismatch.
      set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b0);
      step();
      idle();
      step();
      step();
      wb_valid = 1'b1;
      wb_dst   = 4'd8;
      #2;
      chk("wbm_before", 32'(wb_mismatch), 32'd0);
      step();
      #2;
      chk("wbm_set", 32'(wb_mismatch), 32'd1);
      step();
      step();
      #2;
      chk("wbm_sticky", 32'(wb_mismatch), 32'd1);

      // Reset in the middle of a load-use stall clears everything at once.
      set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
      step();
      set_id(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0);
      #2;
      chk("mr_pre_stall", 32'(stall_id), 32'd1);
      rst = 1'b1;
      #1;
      chk("mr_stall",    32'(stall_id),    32'd0);
      chk("mr_bubble",   32'(bubble_ex),   32'd0);
      chk("mr_pend",     32'(pend_mask),   32'd0);
      chk("mr_mismatch", 32'(wb_mismatch), 32'd0);
      chk("mr_cnt",      32'(stall_cnt),   32'd0);
      step();
      rst = 1'b0;
      drain();
      step();

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
